// File: rtl/turbo_iter_ctrl.sv
// Turbo decoder iteration scheduler: alternates one SISO between natural and interleaved
// half-iterations, streams extrinsic writes, emits hard bits. Optional: TURBO_EARLY_STOP_EN.
module turbo_iter_ctrl #(
  parameter int BLOCK_SIZE = 21,
  parameter int ADDR_W     = 5,
  parameter int LLR_W      = 10,
  parameter int MAX_ITER   = 8,
  parameter int STOP_THR   = 64
) (
  input  logic              clk_p_i,
  input  logic              reset_n_i,
  input  logic              start_i,
  input  logic [3:0]        iter_num_i,
  input  logic              siso_done_i,
  input  logic              llr_valid_i,
  input  logic [LLR_W-1:0]  llr_i,
  output logic              busy_o,
  output logic              siso_start_o,
  output logic              siso_sel_o,
  output logic              ext_wr_en_o,
  output logic [ADDR_W-1:0] ext_wr_addr_o,
  output logic [LLR_W-1:0]  ext_wr_data_o,
  output logic              ext_bank_o,
  output logic [3:0]        iter_cnt_o,
  output logic              hard_valid_o,
  output logic              hard_bit_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {IDLE, LAUNCH1, STREAM1, LAUNCH2, STREAM2, FINISH} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        n_iter_q, n_iter_d, iter_q, iter_d, n_iter_req;
  logic              err_q, err_d, bank_q, bank_d;
  logic              wr_en_q, wr_en_d, hv_q, hv_d, hb_q, hb_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LLR_W-1:0]  data_q, data_d;
  logic              hard_half, llr_pos;

  assign n_iter_req = (iter_num_i == 4'd0)             ? 4'd1 :
                      (iter_num_i > MAX_ITER[3:0])     ? MAX_ITER[3:0] : iter_num_i;
  assign llr_pos    = !llr_i[LLR_W-1] && (|llr_i);

`ifdef TURBO_EARLY_STOP_EN
  logic [LLR_W-1:0] min_q, min_d, llr_abs;
  assign llr_abs   = llr_i[LLR_W-1] ? ((~llr_i) + LLR_W'(1)) : llr_i;
  // every STREAM2 may turn out to be the last one, so hard bits go out on each
  assign hard_half = (state_q == STREAM2);
`else
  assign hard_half = (state_q == STREAM2) && (iter_q == n_iter_q - 4'd1);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    n_iter_d = n_iter_q;
    iter_d   = iter_q;
    err_d    = err_q;
    bank_d   = bank_q;
    wr_en_d  = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    hv_d     = 1'b0;
    hb_d     = hb_q;
`ifdef TURBO_EARLY_STOP_EN
    min_d    = min_q;
`endif
    case (state_q)
      IDLE: if (start_i) begin
        state_d  = LAUNCH1;
        n_iter_d = n_iter_req;
        err_d    = 1'b0;
        iter_d   = 4'd0;
        bank_d   = 1'b0;
      end
      LAUNCH1: begin
        cnt_d   = '0;
        state_d = STREAM1;
      end
      LAUNCH2: begin
        cnt_d   = '0;
        state_d = STREAM2;
`ifdef TURBO_EARLY_STOP_EN
        min_d   = '1;
`endif
      end
      STREAM1, STREAM2: begin
        if (llr_valid_i) begin
          if (cnt_q < BLOCK_SIZE[CNT_W-1:0]) begin
            wr_en_d = 1'b1;
            addr_d  = cnt_q[ADDR_W-1:0];
            data_d  = llr_i;
            cnt_d   = cnt_q + CNT_W'(1);
            hv_d    = hard_half;
            if (hard_half) hb_d = llr_pos;
`ifdef TURBO_EARLY_STOP_EN
            if (state_q == STREAM2 && llr_abs < min_q) min_d = llr_abs;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
        // an LLR arriving with the done is already folded into cnt_d/err_d/min_d
        if (siso_done_i) begin
          if (cnt_d != BLOCK_SIZE[CNT_W-1:0]) err_d = 1'b1;
          bank_d = ~bank_q;
          if (state_q == STREAM1) begin
            state_d = LAUNCH2;
          end else begin
            iter_d  = iter_q + 4'd1;
            state_d = (iter_d == n_iter_q) ? FINISH : LAUNCH1;
`ifdef TURBO_EARLY_STOP_EN
            if (min_d >= STOP_THR[LLR_W-1:0] && !err_d) state_d = FINISH;
`endif
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      n_iter_q <= 4'd1;
      iter_q   <= 4'd0;
      err_q    <= 1'b0;
      bank_q   <= 1'b0;
      wr_en_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      hv_q     <= 1'b0;
      hb_q     <= 1'b0;
`ifdef TURBO_EARLY_STOP_EN
      min_q    <= '1;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      n_iter_q <= n_iter_d;
      iter_q   <= iter_d;
      err_q    <= err_d;
      bank_q   <= bank_d;
      wr_en_q  <= wr_en_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      hv_q     <= hv_d;
      hb_q     <= hb_d;
`ifdef TURBO_EARLY_STOP_EN
      min_q    <= min_d;
`endif
    end
  end

  assign busy_o        = (state_q != IDLE);
  assign siso_start_o  = (state_q == LAUNCH1) || (state_q == LAUNCH2);
  assign siso_sel_o    = (state_q == LAUNCH2) || (state_q == STREAM2);
  assign done_o        = (state_q == FINISH);
  assign ext_wr_en_o   = wr_en_q;
  assign ext_wr_addr_o = addr_q;
  assign ext_wr_data_o = data_q;
  assign ext_bank_o    = bank_q;
  assign iter_cnt_o    = iter_q;
  assign hard_valid_o  = hv_q;
  assign hard_bit_o    = hb_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_turbo_iter_ctrl.sv
// Randomized bench for turbo_iter_ctrl with a per-half-iteration reference model.
module tb_turbo_iter_ctrl;
  localparam int BS = 21, AW = 5, LW = 10, MI = 8, THR = 64;
`ifdef TURBO_EARLY_STOP_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic start_i = 1'b0, siso_done_i = 1'b0, llr_valid_i = 1'b0;
  logic [3:0] iter_num_i = 4'd0;
  logic [LW-1:0] llr_i = '0;
  logic busy_o, siso_start_o, siso_sel_o, ext_wr_en_o, ext_bank_o;
  logic hard_valid_o, hard_bit_o, done_o, err_o;
  logic [AW-1:0] ext_wr_addr_o;
  logic [LW-1:0] ext_wr_data_o;
  logic [3:0] iter_cnt_o;

  turbo_iter_ctrl #(.BLOCK_SIZE(BS), .ADDR_W(AW), .LLR_W(LW), .MAX_ITER(MI), .STOP_THR(THR)) dut (
    .clk_p_i(clk), .reset_n_i(rst_n), .start_i(start_i), .iter_num_i(iter_num_i),
    .siso_done_i(siso_done_i), .llr_valid_i(llr_valid_i), .llr_i(llr_i),
    .busy_o(busy_o), .siso_start_o(siso_start_o), .siso_sel_o(siso_sel_o),
    .ext_wr_en_o(ext_wr_en_o), .ext_wr_addr_o(ext_wr_addr_o), .ext_wr_data_o(ext_wr_data_o),
    .ext_bank_o(ext_bank_o), .iter_cnt_o(iter_cnt_o), .hard_valid_o(hard_valid_o),
    .hard_bit_o(hard_bit_o), .done_o(done_o), .err_o(err_o));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // observed traffic
  logic [1:0]       mon_sel[$];
  logic [AW+LW-1:0] mon_wr[$];
  logic             mon_hard[$];
  int               mon_done;
  logic [3:0]       mon_iter;
  logic             mon_err;
  // model expectations
  logic [AW+LW-1:0] exp_wr[$];
  logic             exp_hard[$];
  int               exp_halves, exp_iter;
  logic             exp_err;

  wire [27:0] all_out = {busy_o, siso_start_o, siso_sel_o, ext_wr_en_o, ext_wr_addr_o, ext_wr_data_o,
                         ext_bank_o, iter_cnt_o, hard_valid_o, hard_bit_o, done_o, err_o};

  always @(negedge clk) if (rst_n) begin
    if (siso_start_o) mon_sel.push_back({siso_sel_o, ext_bank_o});
    if (ext_wr_en_o)  mon_wr.push_back({ext_wr_addr_o, ext_wr_data_o});
    if (hard_valid_o) mon_hard.push_back(hard_bit_o);
    if (done_o) begin mon_done++; mon_iter = iter_cnt_o; mon_err = err_o; end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic do_reset();
    rst_n = 1'b0; start_i = 0; siso_done_i = 0; llr_valid_i = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Drives a whole block as the SISO would and builds the expected traffic.
  // mode 0: random LLRs, 1: +5,0,-3 cycle, 2: |LLR| >= THR.
  task automatic run_block(input int req, input int short_h, input int extra_h,
                           input int mode, input int abort_h);
    int n, h, iters, nllr, mn, mag;
    bit fin, errm, simul, hard_half, got;
    logic signed [LW-1:0] v;
    mon_sel.delete(); mon_wr.delete(); mon_hard.delete(); mon_done = 0;
    exp_wr.delete(); exp_hard.delete();
    n = (req == 0) ? 1 : ((req > MI) ? MI : req);
    iter_num_i = 4'(req); start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    h = 0; iters = 0; errm = 0; fin = 0;
    while (!fin) begin
      got = 0;
      for (int w = 0; w < 20 && !got; w++) begin
        if (siso_start_o) got = 1;
        else begin @(posedge clk); #1; end
      end
      if (!got) begin
        checks++; errors++;
        $display("FAIL launch_timeout half=%0d: saw no siso_start_o in 20 cycles, required one", h);
        return;
      end
      @(posedge clk); #1;
      nllr = (h == short_h) ? BS - 1 : ((h == extra_h) ? BS + 1 : BS);
      if (nllr != BS) errm = 1;
      hard_half = (h % 2 == 1) && (EARLY || iters == n - 1);
      mn = 1 << LW;
      simul = 1'($urandom_range(0, 1));
      for (int i = 0; i < nllr; i++) begin
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        case (mode)
          1: v = (i % 3 == 0) ? LW'(5) : ((i % 3 == 1) ? LW'(0) : LW'(-3));
          2: begin
            mag = $urandom_range(THR, 511);
            v = ($urandom_range(0, 1) == 1) ? LW'(mag) : LW'(-mag);
          end
          default: v = LW'($urandom_range(0, 1023));
        endcase
        llr_valid_i = 1'b1; llr_i = v;
        start_i = 1'($urandom_range(0, 1)); iter_num_i = 4'($urandom_range(0, 15));
        siso_done_i = (i == nllr - 1) && simul;
        if (i < BS) begin
          exp_wr.push_back({AW'(i), v});
          if (hard_half) exp_hard.push_back(v > 0);
          mag = (v < 0) ? -int'(v) : int'(v);
          if (mag < mn) mn = mag;
        end
        @(posedge clk); #1;
        llr_valid_i = 1'b0; siso_done_i = 1'b0; start_i = 1'b0;
        if (h == abort_h && i == 10) begin rst_n = 1'b0; return; end
      end
      if (!simul) begin siso_done_i = 1'b1; @(posedge clk); #1; siso_done_i = 1'b0; end
      if (h % 2 == 1) begin
        iters++;
        fin = (iters == n) || (EARLY && mn >= THR && !errm);
      end
      h++;
    end
    exp_halves = h; exp_iter = iters; exp_err = errm;
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL done_timing: done=%b busy=%b, required 1 1 the cycle after last siso_done", done_o, busy_o);
    end
    @(posedge clk); #1;
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_done: done=%b busy=%b, required 0 0", done_o, busy_o);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_outputs: got %h required 0", all_out); end
    do_reset();
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL idle_outputs: got %h required 0", all_out); end
  endtask

  task automatic test_blocks();
    int reqs[6]   = '{2, 0, 15, 1, 3, 2};
    int shorts[6] = '{-1, -1, -1, 0, -1, 2};
    int extras[6] = '{-1, -1, -1, -1, 3, -1};
    int bad;
    for (int k = 0; k < 6; k++) begin
      run_block(reqs[k], shorts[k], extras[k], 0, -1);
      checks++;
      if (mon_sel.size() != exp_halves) begin
        errors++; $display("FAIL launches blk=%0d got %0d required %0d", k, mon_sel.size(), exp_halves);
      end
      bad = 0;
      for (int i = 0; i < mon_sel.size(); i++) if (mon_sel[i] !== {i[0], i[0]}) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL sel_bank_seq blk=%0d got %0d wrong entries required 0", k, bad); end
      bad = (mon_wr.size() != exp_wr.size()) ? 1 : 0;
      if (bad == 0) for (int i = 0; i < exp_wr.size(); i++) if (mon_wr[i] !== exp_wr[i]) bad++;
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL writes blk=%0d got %0d writes (%0d bad) required %0d", k, mon_wr.size(), bad, exp_wr.size());
      end
      bad = (mon_hard.size() != exp_hard.size()) ? 1 : 0;
      if (bad == 0) for (int i = 0; i < exp_hard.size(); i++) if (mon_hard[i] !== exp_hard[i]) bad++;
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL hard blk=%0d got %0d bits (%0d bad) required %0d", k, mon_hard.size(), bad, exp_hard.size());
      end
      checks++;
      if (mon_done != 1) begin errors++; $display("FAIL done_count blk=%0d got %0d required 1", k, mon_done); end
      checks++;
      if (mon_iter !== 4'(exp_iter)) begin errors++; $display("FAIL iter_cnt blk=%0d got %0d required %0d", k, mon_iter, exp_iter); end
      checks++;
      if (mon_err !== exp_err) begin errors++; $display("FAIL err blk=%0d got %b required %b", k, mon_err, exp_err); end
    end
  endtask

  task automatic test_hard_values();
    int bad;
    logic req_bit;
    run_block(1, -1, -1, 1, -1);
    bad = (mon_hard.size() != BS) ? 1 : 0;
    if (bad == 0) for (int i = 0; i < BS; i++) begin
      req_bit = (i % 3 == 0);
      if (mon_hard[i] !== req_bit) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL hard_5_0_m3: got %0d bits (%0d bad) required %0d", mon_hard.size(), bad, BS); end
    bad = (mon_wr.size() != 2 * BS) ? 1 : 0;
    if (bad == 0) for (int i = 0; i < 2 * BS; i++) if (mon_wr[i][AW+LW-1:LW] !== AW'(i % BS)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL addr_seq: got %0d writes (%0d bad addr) required %0d", mon_wr.size(), bad, 2 * BS); end
  endtask

  task automatic test_reset_mid();
    int bad;
    run_block(3, -1, -1, 0, 3);
    #1;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_mid_outputs: got %h required 0", all_out); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_block(2, -1, -1, 0, -1);
    bad = (mon_wr.size() != exp_wr.size()) ? 1 : 0;
    if (bad == 0) for (int i = 0; i < exp_wr.size(); i++) if (mon_wr[i] !== exp_wr[i]) bad++;
    checks++;
    if (bad != 0 || mon_done != 1 || mon_iter !== 4'(exp_iter) || mon_err !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_block: done=%0d iter=%0d err=%b badwr=%0d required 1 %0d 0 0", mon_done, mon_iter, mon_err, bad, exp_iter);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      run_block(k + 1, -1, -1, 0, -1);
      checks++;
      if (mon_done != 1 || mon_iter !== 4'(exp_iter) || mon_sel.size() != exp_halves || mon_wr.size() != exp_wr.size()) begin
        errors++;
        $display("FAIL back_to_back blk=%0d: done=%0d iter=%0d halves=%0d writes=%0d required 1 %0d %0d %0d",
                 k, mon_done, mon_iter, mon_sel.size(), mon_wr.size(), exp_iter, exp_halves, exp_wr.size());
      end
    end
  endtask

  task automatic test_early_stop();
    run_block(8, -1, -1, 2, -1);
    checks++;
    if (mon_sel.size() != (EARLY ? 2 : 16) || mon_iter !== (EARLY ? 4'd1 : 4'd8) || mon_done != 1) begin
      errors++;
      $display("FAIL early_stop: halves=%0d iter=%0d done=%0d required %0d %0d 1",
               mon_sel.size(), mon_iter, mon_done, EARLY ? 2 : 16, EARLY ? 1 : 8);
    end
  endtask

  initial begin
    test_reset();
    test_blocks();
    test_hard_values();
    test_reset_mid();
    test_back_to_back();
    test_early_stop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
